rom_loader_ctrl: RTL and testbench
==================================

# rom_loader_ctrl

Controller that sequences program download into the SoC instruction ROM over UART and holds the CPU in reset while the download runs. It sits between the UART receiver byte output and the ROM write port, next to the CPU reset input, inside the SoC top. It assembles received bytes MSB-first into 32-bit instruction words and writes them to consecutive ROM word addresses starting at 0. An idle-line timeout ends the download and releases the CPU so it fetches from address 0.

## Interface
- ADDR_W, 12, ROM word-address width; ROM depth = 2^ADDR_W words
- TIMEOUT_CYCLES, 200000, idle cycles after the last byte that end a download (about 4 byte times at 9600 baud, 50 MHz)
- RST_PULSE, 16, cycles `cpu_rst` stays high in RELEASE

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from the UART receiver
- rx_valid  in  1  one-cycle strobe; `rx_data` is valid this cycle
- rom_we  out  1  ROM write strobe, one cycle per word
- rom_waddr  out  ADDR_W  ROM word address
- rom_wdata  out  32  instruction word
- cpu_rst  out  1  active-high CPU reset/hold
- load_busy  out  1  high in LOAD
- word_cnt  out  ADDR_W+1  words written in the current or last download
- err_partial  out  1  sticky: download ended with 1–3 bytes of an incomplete word
- err_overflow  out  1  sticky: more than 2^ADDR_W words were received

## Operation
- States: RELEASE, RUN, LOAD.
- Reset values:
  - state=RELEASE, `cpu_rst`=1, `rom_we`=0, `rom_waddr`=0, `rom_wdata`=0
  - `load_busy`=0, `word_cnt`=0, both error flags=0
  - byte_idx=0, idle timer=0, pulse counter=0
- RELEASE:
  - `cpu_rst`=1.
  - The pulse counter counts up to RST_PULSE-1, then the state goes to RUN.
  - `rx_valid` in RELEASE goes to LOAD, with the same actions as in RUN.
- RUN:
  - `cpu_rst`=0.
  - `rx_valid` goes to LOAD and stores the byte as byte 0.
  - On that entry: byte_idx=1, write address=0, `word_cnt`=0, both error flags cleared, idle timer=0.
- LOAD:
  - `cpu_rst`=1 and `load_busy`=1.
  - Each `rx_valid` shifts the byte into the assembly register, MSB first: word = {b0,b1,b2,b3}.
  - Each `rx_valid` also increments byte_idx modulo 4 and clears the idle timer.
  - The 4th byte (byte_idx==3 with `rx_valid`) completes the word:
    - if `word_cnt` < 2^ADDR_W: issue a write, then increment the address and `word_cnt`;
    - otherwise: no write and `err_overflow` set. Bytes keep being consumed and discarded until timeout.
  - With no `rx_valid`, the idle timer increments each cycle.
  - Timer == TIMEOUT_CYCLES-1 goes to RELEASE. If byte_idx != 0, `err_partial` is set and the partial word is dropped.
- Address arithmetic: `rom_waddr` is the low ADDR_W bits of `word_cnt`. `word_cnt` saturates at 2^ADDR_W.
- `rst` at any time, including mid-word or mid-write, returns to the reset values. A partial word is lost and no `rom_we` is issued in the reset cycle.

## Timing
- All outputs are registered.
- `cpu_rst` rises the cycle after the first `rx_valid` seen in RUN.
- `rom_we` is a single-cycle pulse in the cycle after the completing `rx_valid`. `rom_waddr` and `rom_wdata` are valid in the same cycle and hold until the next write.
- `word_cnt` updates together with `rom_we`.
- A byte arriving in the same cycle as `rom_we` is accepted as byte 0 of the next word; no byte is lost. Back-to-back `rx_valid` on every cycle is supported.
- Timeout and `rx_valid` in the same cycle: the byte wins and the timer clears.
- `cpu_rst` falls exactly RST_PULSE cycles after entering RELEASE.
- Download latency: 1 cycle per word.
- Release latency after the last byte: TIMEOUT_CYCLES + RST_PULSE cycles.

## Test plan
- **Reset release:** assert `rst` for 3 cycles, then release → `cpu_rst`=1 for 16 cycles, then 0. `rom_we` never pulses and `word_cnt`=0.
- **Program download:** send bytes 00 10 00 93, 00 20 01 13, 00 10 80 B3, FE 20 8E E3 → four `rom_we` pulses with:
  - addr 0 = 0x00100093
  - addr 1 = 0x00200113
  - addr 2 = 0x001080B3
  - addr 3 = 0xFE208EE3

  Then after timeout: `word_cnt`=4, no error flags, `cpu_rst` drops after 16 more cycles.
- **Partial word:** send 5 bytes 11 22 33 44 55, then idle → a single write of 0x11223344 at addr 0, `err_partial`=1, `word_cnt`=1, CPU released.
- **Overflow:** with ADDR_W=2, send 5 full words → 4 writes at addr 0–3, 5th word dropped, `err_overflow`=1, `word_cnt`=4.
- **Reset mid-word:** assert `rst` after bytes AA BB → no `rom_we`, all outputs at reset values. A fresh download then starts at addr 0.
- **Back-to-back bytes with timeout race:** drive `rx_valid` on 8 consecutive cycles, and separately a byte exactly on timer == TIMEOUT_CYCLES-1 → the byte is accepted, the state stays LOAD, and the words are written correctly.

Source files
------------

// File: rtl/rom_loader_if.sv
// Byte-in / ROM-write-out bundle of the boot ROM loader, plus its CPU-hold and status lines.
// master = loader side, slave = UART/ROM/CPU environment side.
interface rom_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [31:0]       rom_wdata;
    logic              cpu_rst;
    logic              load_busy;
    logic [ADDR_W:0]   word_cnt;
    logic              err_partial;
    logic              err_overflow;

    modport master (
        input  rx_data, rx_valid,
        output rom_we, rom_waddr, rom_wdata, cpu_rst, load_busy,
               word_cnt, err_partial, err_overflow
    );

    modport slave (
        output rx_data, rx_valid,
        input  rom_we, rom_waddr, rom_wdata, cpu_rst, load_busy,
               word_cnt, err_partial, err_overflow
    );
endinterface

// File: rtl/rom_loader_ctrl.sv
// Boot loader: packs UART bytes MSB-first into 32-bit words, writes them to ROM from
// address 0, and holds the CPU in reset until the line has been idle long enough.
module rom_loader_ctrl #(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int RST_PULSE      = 16
) (
    input  logic         clk,
    input  logic         rst,
    rom_loader_if.master bus
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(RST_PULSE + 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);

    typedef enum logic [1:0] {
        RELEASE = 2'd0,
        RUN     = 2'd1,
        LOAD    = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     pulse_reg, pulse_next;
    logic [IW-1:0]     idle_reg, idle_next;
    logic [1:0]        byte_idx_reg, byte_idx_next;
    logic              rom_we_reg, rom_we_next;
    logic [ADDR_W-1:0] rom_waddr_reg, rom_waddr_next;
    logic [31:0]       rom_wdata_reg, rom_wdata_next;
    logic              cpu_rst_reg, cpu_rst_next;
    logic              load_busy_reg, load_busy_next;
    logic [ADDR_W:0]   word_cnt_reg, word_cnt_next;
    logic              err_partial_reg, err_partial_next;
    logic              err_overflow_reg, err_overflow_next;
    logic [31:0]       word_full;

    // Byte lanes 0..2 of the word being assembled; lane 3 is taken straight from rx_data
    // on the completing byte, so a word can be written the cycle after its last byte.
    // byte_idx is 0 outside LOAD, so the first byte of a download always lands in lane 0.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg <= '0;
                end else if (bus.rx_valid && byte_idx_reg == 2'(gi)) begin
                    lane_reg <= bus.rx_data;
                end
            end
        end
    endgenerate

    assign word_full = {g_lane[0].lane_reg, g_lane[1].lane_reg, g_lane[2].lane_reg, bus.rx_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= RELEASE;
            pulse_reg        <= '0;
            idle_reg         <= '0;
            byte_idx_reg     <= '0;
            rom_we_reg       <= 1'b0;
            rom_waddr_reg    <= '0;
            rom_wdata_reg    <= '0;
            cpu_rst_reg      <= 1'b1;
            load_busy_reg    <= 1'b0;
            word_cnt_reg     <= '0;
            err_partial_reg  <= 1'b0;
            err_overflow_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pulse_reg        <= pulse_next;
            idle_reg         <= idle_next;
            byte_idx_reg     <= byte_idx_next;
            rom_we_reg       <= rom_we_next;
            rom_waddr_reg    <= rom_waddr_next;
            rom_wdata_reg    <= rom_wdata_next;
            cpu_rst_reg      <= cpu_rst_next;
            load_busy_reg    <= load_busy_next;
            word_cnt_reg     <= word_cnt_next;
            err_partial_reg  <= err_partial_next;
            err_overflow_reg <= err_overflow_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        pulse_next        = pulse_reg;
        idle_next         = idle_reg;
        byte_idx_next     = byte_idx_reg;
        rom_we_next       = 1'b0;
        rom_waddr_next    = rom_waddr_reg;
        rom_wdata_next    = rom_wdata_reg;
        word_cnt_next     = word_cnt_reg;
        err_partial_next  = err_partial_reg;
        err_overflow_next = err_overflow_reg;

        case (state_reg)
            RELEASE, RUN: begin
                // A byte starts a new download even while the CPU is still in its reset pulse.
                if (bus.rx_valid) begin
                    state_next        = LOAD;
                    byte_idx_next     = 2'd1;
                    idle_next         = '0;
                    pulse_next        = '0;
                    word_cnt_next     = '0;
                    err_partial_next  = 1'b0;
                    err_overflow_next = 1'b0;
                end else if (state_reg == RELEASE) begin
                    if (pulse_reg == PULSE_LAST) begin
                        state_next = RUN;
                        pulse_next = '0;
                    end else begin
                        pulse_next = pulse_reg + 1'b1;
                    end
                end
            end
            LOAD: begin
                // A byte on the final idle cycle still wins over the timeout.
                if (bus.rx_valid) begin
                    idle_next     = '0;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        if (!word_cnt_reg[ADDR_W]) begin
                            rom_we_next    = 1'b1;
                            rom_waddr_next = word_cnt_reg[ADDR_W-1:0];
                            rom_wdata_next = word_full;
                            word_cnt_next  = word_cnt_reg + 1'b1;
                        end else begin
                            err_overflow_next = 1'b1;
                        end
                    end
                end else if (idle_reg == IDLE_LAST) begin
                    state_next    = RELEASE;
                    idle_next     = '0;
                    pulse_next    = '0;
                    byte_idx_next = '0;
                    if (byte_idx_reg != 2'd0) begin
                        err_partial_next = 1'b1;
                    end
                end else begin
                    idle_next = idle_reg + 1'b1;
                end
            end
            default: begin
                state_next = RELEASE;
            end
        endcase

        cpu_rst_next   = (state_next != RUN);
        load_busy_next = (state_next == LOAD);
    end

    assign bus.rom_we       = rom_we_reg;
    assign bus.rom_waddr    = rom_waddr_reg;
    assign bus.rom_wdata    = rom_wdata_reg;
    assign bus.cpu_rst      = cpu_rst_reg;
    assign bus.load_busy    = load_busy_reg;
    assign bus.word_cnt     = word_cnt_reg;
    assign bus.err_partial  = err_partial_reg;
    assign bus.err_overflow = err_overflow_reg;
endmodule

// File: tb/tb_rom_loader_ctrl.sv
// Self-checking bench for rom_loader_ctrl: expected ROM writes go into a scoreboard queue
// that a negedge monitor drains; download status and release timing are checked per download.
module tb_rom_loader_ctrl;
    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 24;
    localparam int PULSE   = 16;
    localparam int DEPTH   = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

    rom_loader_ctrl #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT),
        .RST_PULSE(PULSE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] dl_bytes[$];
    int         dl_gaps[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every ROM write must match the next expected one.
    always @(negedge clk) begin
        if (bus.rom_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, required no write",
                         bus.rom_waddr, bus.rom_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(bus.rom_waddr), 32'(mon_e.addr));
                check("write_data", bus.rom_wdata, mon_e.data);
                $display("write addr %0d data 0x%08h", bus.rom_waddr, bus.rom_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    // Reference model: complete words land at consecutive addresses up to ROM depth;
    // status follows from byte count alone. Then drives bytes and waits for CPU release.
    task automatic run_download(input string tag);
        int  nb, nw, n, busy_n;
        wr_t e;
        nb = dl_bytes.size();
        nw = nb / 4;
        for (int w = 0; w < nw && w < DEPTH; w++) begin
            e.addr = ADDR_W'(w);
            e.data = {dl_bytes[4*w], dl_bytes[4*w+1], dl_bytes[4*w+2], dl_bytes[4*w+3]};
            exp_q.push_back(e);
        end
        for (int i = 0; i < nb; i++) begin
            repeat (dl_gaps[i]) tick();
            send_byte(dl_bytes[i]);
            check({tag, "_busy"}, 32'(bus.load_busy), 32'd1);
            check({tag, "_cpu_hold"}, 32'(bus.cpu_rst), 32'd1);
            check({tag, "_we_timing"}, 32'(bus.rom_we), 32'((i % 4 == 3) && (i / 4 < DEPTH)));
        end
        n = 0;
        busy_n = -1;
        while (bus.cpu_rst === 1'b1 && n < TIMEOUT + PULSE + 20) begin
            tick();
            n++;
            if (busy_n < 0 && bus.load_busy !== 1'b1) busy_n = n;
        end
        check({tag, "_timeout_len"}, 32'(busy_n), 32'(TIMEOUT));
        check({tag, "_release_len"}, 32'(n), 32'(TIMEOUT + PULSE));
        check({tag, "_word_cnt"}, 32'(bus.word_cnt), 32'((nw < DEPTH) ? nw : DEPTH));
        check({tag, "_err_partial"}, 32'(bus.err_partial), 32'(nb % 4 != 0));
        check({tag, "_err_overflow"}, 32'(bus.err_overflow), 32'(nw > DEPTH));
        $display("download %s: %0d bytes, word_cnt %0d, partial %0b, overflow %0b, release after %0d",
                 tag, nb, bus.word_cnt, bus.err_partial, bus.err_overflow, n);
    endtask

    task automatic do_reset(input int cycles, input bit wait_release);
        int n;
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (cycles) tick();
        check("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check("rst_rom_we", 32'(bus.rom_we), 32'd0);
        check("rst_rom_waddr", 32'(bus.rom_waddr), 32'd0);
        check("rst_rom_wdata", bus.rom_wdata, 32'd0);
        check("rst_load_busy", 32'(bus.load_busy), 32'd0);
        check("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
        check("rst_err_partial", 32'(bus.err_partial), 32'd0);
        check("rst_err_overflow", 32'(bus.err_overflow), 32'd0);
        rst = 1'b0;
        if (wait_release) begin
            n = 0;
            while (bus.cpu_rst === 1'b1 && n < PULSE + 20) begin
                tick();
                n++;
            end
            check("rst_release_len", 32'(n), 32'(PULSE));
            check("rst_release_word_cnt", 32'(bus.word_cnt), 32'd0);
        end
        $display("reset %0d cycles done", cycles);
    endtask

    task automatic load_fixed(input logic [31:0] w0, input int nwords, input int nextra, input int gap);
        logic [31:0] w;
        dl_bytes.delete();
        dl_gaps.delete();
        for (int k = 0; k < nwords * 4 + nextra; k++) begin
            w = w0 + 32'(k / 4) * 32'h01010101;
            dl_bytes.push_back(w[31 - 8 * (k % 4) -: 8]);
            dl_gaps.push_back(gap);
        end
    endtask

    initial begin
        logic [31:0] prog [4];
        int r;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        tick();

        // Reset release
        do_reset(3, 1'b1);

        // Program download
        prog[0] = 32'h00100093;
        prog[1] = 32'h00200113;
        prog[2] = 32'h001080B3;
        prog[3] = 32'hFE208EE3;
        dl_bytes.delete();
        dl_gaps.delete();
        for (int k = 0; k < 16; k++) begin
            dl_bytes.push_back(prog[k / 4][31 - 8 * (k % 4) -: 8]);
            dl_gaps.push_back($urandom_range(0, 2));
        end
        run_download("program");

        // Partial word
        dl_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        dl_gaps  = '{1, 0, 2, 0, 1};
        run_download("partial");

        // Overflow: five words into a four-word ROM
        load_fixed(32'hA0B0C0D0, 5, 0, 1);
        run_download("overflow");

        // Reset with flags, data and address all non-zero
        do_reset(2, 1'b1);

        // Reset mid-word, the final byte arriving together with rst
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        bus.rx_data  = 8'hDD;
        bus.rx_valid = 1'b1;
        rst = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        do_reset(2, 1'b0);

        // Fresh download begun during the reset pulse starts at address 0
        load_fixed(32'h13579BDF, 2, 0, 0);
        dl_gaps[0] = 2;
        run_download("after_reset");

        // Back-to-back bytes, then bytes landing exactly on the last idle cycle
        load_fixed(32'h01234567, 3, 0, 0);
        for (int k = 8; k < 12; k++) dl_gaps[k] = TIMEOUT - 1;
        run_download("race");

        // Randomized downloads
        for (int t = 0; t < 8; t++) begin
            dl_bytes.delete();
            dl_gaps.delete();
            for (int k = 0; k < int'($urandom_range(1, 22)); k++) begin
                dl_bytes.push_back(8'($urandom));
                r = $urandom_range(0, 9);
                dl_gaps.push_back((r < 6) ? 0 : (r < 8) ? int'($urandom_range(1, 4)) : TIMEOUT - 1);
            end
            dl_gaps[0] = $urandom_range(0, 3);
            run_download($sformatf("random%0d", t));
        end

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
